decrypt_controller: RTL
=======================

DECRYPT_CONTROLLER -- requirements
Module: decrypt_controller

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles dp_enable is held before dp_m_b is sampled (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port load_key, input, 1, a pulse that starts secret-key loading.
REQ-005 The block SHALL have port decrypt_start, input, 1, a pulse that starts ciphertext loading and decryption.
REQ-006 The block SHALL have port in_valid, input, 1, operand word valid.
REQ-007 The block SHALL have port in_ready, output, 1, operand word accepted when in_valid and in_ready are both high.
REQ-008 The block SHALL have port in_data, input, 32, a signed operand coefficient.
REQ-009 The block SHALL have port dp_enable, output, 1, the datapath enable.
REQ-010 The block SHALL have port dp_secret_key, output, 2x4x32 signed, the key operand registers.
REQ-011 The block SHALL have port dp_ciphertext, output, 2x2x4x32 signed, the ciphertext operand registers.
REQ-012 The block SHALL have port dp_m_b, input, 4, the decoded message bits from the datapath.
REQ-013 The block SHALL have port out_valid, output, 1, message valid.
REQ-014 The block SHALL have port out_ready, input, 1, message consumed.
REQ-015 The block SHALL have port out_msg, output, 4, the captured message; bit i is coefficient i.
REQ-016 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 The block SHALL have port key_loaded, output, 1, high when a complete key is held.
REQ-018 The block SHALL have port err, output, 1, a one-cycle pulse on an illegal command.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD_KEY, LOAD_CT, RUN and DONE.
REQ-020 In IDLE, load_key SHALL cause a transition to LOAD_KEY, clear key_loaded and clear the word counter.
REQ-021 In IDLE, decrypt_start with load_key low SHALL go to LOAD_CT if key_loaded is 1; otherwise it SHALL pulse err for 1 cycle and stay in IDLE.
REQ-022 When load_key and decrypt_start are high in the same IDLE cycle, load_key SHALL take priority, with no err.
REQ-023 load_key and decrypt_start SHALL be ignored outside IDLE, with no err.
REQ-024 in_ready SHALL be 1 only in LOAD_KEY and LOAD_CT; in_valid SHALL be ignored in all other states.
REQ-025 In LOAD_KEY, accepted word k (0..7) SHALL be written to dp_secret_key[k[2]][k[1:0]].
REQ-026 After the 8th accepted key word, the FSM SHALL go to IDLE and key_loaded SHALL be set on the next cycle.
REQ-027 In LOAD_CT, accepted word k (0..15) SHALL be written to dp_ciphertext[k[3]][k[2]][k[1:0]].
REQ-028 After the 16th accepted ciphertext word, the FSM SHALL go to RUN.
REQ-029 Gaps in in_valid SHALL stall the word counter without loss or duplication of words.
REQ-030 The word counter SHALL be 5 bits, SHALL reset to 0 on entry to each load state, and SHALL never wrap.
REQ-031 dp_enable SHALL be 1 exactly during RUN: if the last word is accepted in cycle T, RUN occupies cycles T+1..T+LATENCY.
REQ-032 The block SHALL sample dp_m_b into out_msg in the final RUN cycle and enter DONE.
REQ-033 out_valid SHALL be 1 from cycle T+LATENCY+1.
REQ-034 In DONE, out_valid and out_msg SHALL be held stable until out_ready is high.
REQ-035 When out_ready is high in DONE, the FSM SHALL go to IDLE with out_valid low in the next cycle.
REQ-036 An out_ready that is already high on DONE entry SHALL complete the handshake in 1 cycle.
REQ-037 The key registers and key_loaded SHALL persist across decryptions; the ciphertext registers SHALL hold their values until the next LOAD_CT overwrites them.
REQ-038 Operand registers SHALL be driven directly with no arithmetic; modular reduction mod 17 belongs to the datapath.

Reset
REQ-039 On rst, the block SHALL set state to IDLE, counters to 0, all operand registers to 0, and dp_enable, in_ready, out_valid, out_msg, busy, key_loaded and err to 0.
REQ-040 rst asserted mid-operation SHALL abort that operation, discard partial data and clear key_loaded, with no out_valid emitted.

Structure
REQ-041 Package decrypt_ctrl_pkg SHALL hold the state enum and the constants N_COEF=4, K=2, KEY_WORDS=8, CT_WORDS=16 and Q=17.
REQ-042 The design SHALL use one sub-module, decrypt_operand_buf, which holds the key and ciphertext register files with an indexed write port and a synchronous clear.

Verification
REQ-043 Bench: release rst -> all outputs 0, busy=0, in_ready=0.
REQ-044 Bench: decrypt_start with no key -> err=1 for exactly 1 cycle, state stays IDLE, in_ready=0.
REQ-045 Bench: load_key, then 8 words 1..8 with in_valid low every other cycle -> dp_secret_key[1][3]=8, key_loaded=1 after the 8th word, busy falls.
REQ-046 Bench: with key all 0, ciphertext v coefficients {0,9,9,0}, LATENCY=2 and dp_m_b model returning 4'b0110 -> dp_enable high 2 cycles, out_valid at T+3, out_msg=4'h6, held 5 cycles with out_ready low, cleared 1 cycle after out_ready.
REQ-047 Bench: rst after 5 ciphertext words -> IDLE, key_loaded=0, dp_enable never asserted.
REQ-048 Bench: load_key and decrypt_start in the same cycle -> LOAD_KEY entered, err=0.

Source files
------------

// File: rtl/decrypt_ctrl_pkg.sv
// decrypt_ctrl_pkg: shared states and operand geometry for the decrypt controller
package decrypt_ctrl_pkg;
    localparam int N_COEF    = 4;
    localparam int K         = 2;
    localparam int KEY_WORDS = 8;
    localparam int CT_WORDS  = 16;
    localparam int Q         = 17;
    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_CT, RUN, DONE} state_t;
endpackage

// File: rtl/decrypt_operand_buf.sv
// decrypt_operand_buf: key and ciphertext register files with indexed write and sync clear
module decrypt_operand_buf
    import decrypt_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               we_key,
    input  logic               we_ct,
    input  logic [3:0]         idx,
    input  logic signed [31:0] data,
    output logic signed [31:0] key [K][N_COEF],
    output logic signed [31:0] ct  [2][K][N_COEF]
);
    // word idx lands at key[idx[2]][idx[1:0]] or ct[idx[3]][idx[2]][idx[1:0]]
    always_ff @(posedge clk) begin
        if (clr) begin
            key <= '{default: '0};
            ct  <= '{default: '0};
        end else begin
            if (we_key) key[idx[2]][idx[1:0]] <= data;
            if (we_ct) ct[idx[3]][idx[2]][idx[1:0]] <= data;
        end
    end
endmodule

// File: rtl/decrypt_controller.sv
// decrypt_controller: loads key/ciphertext operands, runs the datapath, returns the message
module decrypt_controller
    import decrypt_ctrl_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_key,
    input  logic               decrypt_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_data,
    output logic               dp_enable,
    output logic signed [31:0] dp_secret_key [K][N_COEF],
    output logic signed [31:0] dp_ciphertext [2][K][N_COEF],
    input  logic [3:0]         dp_m_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_msg,
    output logic               busy,
    output logic               key_loaded,
    output logic               err
);
    state_t     state, state_n;
    logic [4:0] cnt;
    logic [3:0] run_cnt;
    logic       accept, last_word, run_done;

    assign in_ready  = state == LOAD_KEY || state == LOAD_CT;
    assign dp_enable = state == RUN;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign last_word = accept && cnt == (state == LOAD_KEY ? 5'(KEY_WORDS - 1) : 5'(CT_WORDS - 1));
    assign run_done  = dp_enable && run_cnt == 4'(LATENCY - 1);

    decrypt_operand_buf u_buf (
        .clk    (clk),
        .clr    (rst),
        .we_key (accept && state == LOAD_KEY),
        .we_ct  (accept && state == LOAD_CT),
        .idx    (cnt[3:0]),
        .data   (in_data),
        .key    (dp_secret_key),
        .ct     (dp_ciphertext)
    );

    // next state; commands only matter in IDLE, load_key wins over decrypt_start
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = load_key ? LOAD_KEY : (decrypt_start && key_loaded) ? LOAD_CT : IDLE;
            LOAD_KEY: state_n = last_word ? IDLE : LOAD_KEY;
            LOAD_CT:  state_n = last_word ? RUN : LOAD_CT;
            RUN:      state_n = run_done ? DONE : RUN;
            DONE:     state_n = out_ready ? IDLE : DONE;
            default:  state_n = IDLE;
        endcase
    end

    // state, word/run counters, key status, error pulse and message capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            run_cnt    <= '0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
            out_msg    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= state_n != state ? 5'd0 : accept ? cnt + 5'd1 : cnt;
            run_cnt    <= dp_enable ? run_cnt + 4'd1 : 4'd0;
            key_loaded <= (state == IDLE && load_key) ? 1'b0 : (state == LOAD_KEY && last_word) ? 1'b1 : key_loaded;
            err        <= state == IDLE && decrypt_start && !load_key && !key_loaded;
            out_msg    <= run_done ? dp_m_b : out_msg;
        end
    end
endmodule
